// File: rtl/spec_checkpoint_queue.sv
// In-order checkpoint FIFO for multi-branch speculation: allocates per-branch register
// snapshots, resolves oldest-first, and on a mispredict flushes, restores and empties.
module spec_checkpoint_queue #(
    parameter int PC_W      = 8,
    parameter int DATA_W    = 8,
    parameter int NREGS     = 8,
    parameter int MAX_BR    = 4,
    parameter int MAX_INSTS = 7,
    parameter int CNT_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      br_issue,
    input  logic [PC_W-1:0]           br_pc,
    input  logic                      br_pred_taken,
    input  logic [PC_W-1:0]           br_pred_target,
    input  logic [NREGS*DATA_W-1:0]   reg_snapshot,
    input  logic                      inst_valid,
    input  logic                      br_resolve,
    input  logic                      res_taken,
    input  logic [PC_W-1:0]           res_target,
    output logic                      spec_mode,
    output logic [$clog2(MAX_BR):0]   spec_count,
    output logic                      spec_full,
    output logic                      issue_stall,
    output logic                      busy,
    output logic                      flush,
    output logic [PC_W-1:0]           correct_pc,
    output logic                      restore_valid,
    output logic [NREGS*DATA_W-1:0]   restore_regs,
    output logic                      spurious_resolve,
    output logic [CNT_W-1:0]          spec_insts
);
    localparam int PTR_W = $clog2(MAX_BR);
    localparam int CNT_BW = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t state_r, state_nxt;

    logic [PTR_W-1:0]        head_r, tail_r;
    logic [CNT_BW-1:0]       count_r;
    logic [CNT_W-1:0]        insts_r;
    logic                    flush_r, spur_r;
    logic [PC_W-1:0]         cpc_r;
    logic [NREGS*DATA_W-1:0] regs_r;

    logic [PC_W-1:0]         ent_pc    [MAX_BR];
    logic                    ent_taken [MAX_BR];
    logic [PC_W-1:0]         ent_tgt   [MAX_BR];
    logic [NREGS*DATA_W-1:0] ent_snap  [MAX_BR];

    logic run_s, full_s, empty_s, resolve_s, hit_s, correct_s, mispredict_s, alloc_s, budget_s;

    assign run_s        = (state_r == RUN);
    assign full_s       = (count_r == CNT_BW'(MAX_BR));
    assign empty_s      = (count_r == {CNT_BW{1'b0}});
    assign budget_s     = (insts_r == CNT_W'(MAX_INSTS));
    assign resolve_s    = run_s && br_resolve && !empty_s;
    // A not-taken outcome matches on direction alone; the target only matters when taken.
    assign hit_s        = (res_taken == ent_taken[head_r]) &&
                          (!res_taken || (res_target == ent_tgt[head_r]));
    assign correct_s    = resolve_s && hit_s;
    assign mispredict_s = resolve_s && !hit_s;
    // A full queue can still accept a branch when the head retires in the same cycle.
    assign alloc_s      = run_s && br_issue && (!full_s || correct_s) && !mispredict_s;

    // Next-state logic for the recovery sequencer.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            RUN: begin
                if (mispredict_s) begin
                    state_nxt = FLUSH;
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH:   state_nxt = RECOVER;
            RECOVER: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Control state: FSM, pointers, counters and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_BW{1'b0}};
            insts_r <= {CNT_W{1'b0}};
            flush_r <= 1'b0;
            spur_r  <= 1'b0;
            cpc_r   <= {PC_W{1'b0}};
            regs_r  <= {(NREGS*DATA_W){1'b0}};
        end else begin
            state_r <= state_nxt;
            flush_r <= mispredict_s;
            spur_r  <= br_resolve && empty_s;
            if (mispredict_s) begin
                head_r  <= tail_r;
                count_r <= {CNT_BW{1'b0}};
                insts_r <= {CNT_W{1'b0}};
                cpc_r   <= res_taken ? res_target : (ent_pc[head_r] + PC_W'(1));
                regs_r  <= ent_snap[head_r];
            end else begin
                if (correct_s) begin
                    head_r <= head_r + PTR_W'(1);
                end else begin
                    head_r <= head_r;
                end
                if (alloc_s) begin
                    tail_r <= tail_r + PTR_W'(1);
                end else begin
                    tail_r <= tail_r;
                end
                case ({alloc_s, correct_s})
                    2'b10:   count_r <= count_r + CNT_BW'(1);
                    2'b01:   count_r <= count_r - CNT_BW'(1);
                    default: count_r <= count_r;
                endcase
                if (correct_s) begin
                    insts_r <= {CNT_W{1'b0}};
                end else if (inst_valid && run_s && !empty_s && !budget_s) begin
                    insts_r <= insts_r + CNT_W'(1);
                end else begin
                    insts_r <= insts_r;
                end
            end
        end
    end

    // Checkpoint storage; contents are don't-care until allocated.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            ent_pc[tail_r]    <= br_pc;
            ent_taken[tail_r] <= br_pred_taken;
            ent_tgt[tail_r]   <= br_pred_target;
            ent_snap[tail_r]  <= reg_snapshot;
        end
    end

    assign spec_mode        = !empty_s;
    assign spec_count       = count_r;
    assign spec_full        = full_s;
    assign busy             = !run_s;
    assign issue_stall      = full_s || budget_s || !run_s;
    assign flush            = flush_r;
    assign restore_valid    = flush_r;
    assign correct_pc       = cpc_r;
    assign restore_regs     = regs_r;
    assign spurious_resolve = spur_r;
    assign spec_insts       = insts_r;
endmodule
